// File: rtl/mw_load_stage_if.sv
// M-stage inputs and W-stage outputs of the M/W load stage.
interface mw_load_stage_if #(
    parameter int unsigned RETIRE_W = 32
);
    // M-stage side
    logic                IntReq;
    logic                valid_M;
    logic [31:0]         DR;
    logic [31:0]         AO_M;
    logic [31:0]         pc4_M;
    logic [2:0]          ld_type_M;
    logic [1:0]          wd_sel_M;
    logic                RegWrite_M;
    logic [4:0]          A3_M;
    // W-stage side
    logic [31:0]         WD_W;
    logic [4:0]          A3_W;
    logic                WE_W;
    logic [31:0]         pc4_W;
    logic                valid_W;
    logic                adel_W;
    logic [RETIRE_W-1:0] retired;

    modport master (
        output IntReq, valid_M, DR, AO_M, pc4_M, ld_type_M, wd_sel_M, RegWrite_M, A3_M,
        input  WD_W, A3_W, WE_W, pc4_W, valid_W, adel_W, retired
    );

    modport slave (
        input  IntReq, valid_M, DR, AO_M, pc4_M, ld_type_M, wd_sel_M, RegWrite_M, A3_M,
        output WD_W, A3_W, WE_W, pc4_W, valid_W, adel_W, retired
    );
endinterface

// File: rtl/mw_load_stage.sv
// M/W pipeline register plus write-back load formatter, misalignment
// detection and retired-instruction counter.
module mw_load_stage #(
    parameter int unsigned RETIRE_W = 32
) (
    input  logic                clk,
    input  logic                clr,
    mw_load_stage_if.slave      mw
);
    localparam int unsigned XLEN = 32;

    localparam logic [2:0] LD_LW  = 3'd1;
    localparam logic [2:0] LD_LH  = 3'd2;
    localparam logic [2:0] LD_LHU = 3'd3;
    localparam logic [2:0] LD_LB  = 3'd4;
    localparam logic [2:0] LD_LBU = 3'd5;

    localparam logic [1:0] WD_LOAD = 2'd1;
    localparam logic [1:0] WD_LINK = 2'd2;

    logic [XLEN-1:0]     dr_w;
    logic [XLEN-1:0]     ao_w;
    logic [XLEN-1:0]     pc4_w;
    logic [2:0]          ld_type_w;
    logic [1:0]          wd_sel_w;
    logic                regwrite_w;
    logic [4:0]          a3_w;
    logic                valid_w;
    logic [RETIRE_W-1:0] retired_q;

    logic [15:0]         half_c;
    logic [7:0]          byte_c;
    logic [XLEN-1:0]     load_c;
    logic                adel_c;
    logic [XLEN-1:0]     wd_c;
    logic                we_c;

    // M->W capture; an interrupt loads a bubble in place of the M instruction
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            dr_w       <= '0;
            ao_w       <= '0;
            pc4_w      <= '0;
            ld_type_w  <= '0;
            wd_sel_w   <= '0;
            regwrite_w <= 1'b0;
            a3_w       <= '0;
            valid_w    <= 1'b0;
        end else if (mw.IntReq) begin
            dr_w       <= '0;
            ao_w       <= '0;
            pc4_w      <= '0;
            ld_type_w  <= '0;
            wd_sel_w   <= '0;
            regwrite_w <= 1'b0;
            a3_w       <= '0;
            valid_w    <= 1'b0;
        end else begin
            dr_w       <= mw.DR;
            ao_w       <= mw.AO_M;
            pc4_w      <= mw.pc4_M;
            ld_type_w  <= mw.ld_type_M;
            wd_sel_w   <= mw.wd_sel_M;
            regwrite_w <= mw.RegWrite_M;
            a3_w       <= mw.A3_M;
            valid_w    <= mw.valid_M;
        end
    end

    // Byte/halfword extraction, extension and misalignment check
    always_comb begin
        half_c = ao_w[1] ? dr_w[31:16] : dr_w[15:0];
        case (ao_w[1:0])
            2'd1:    byte_c = dr_w[15:8];
            2'd2:    byte_c = dr_w[23:16];
            2'd3:    byte_c = dr_w[31:24];
            default: byte_c = dr_w[7:0];
        endcase
        load_c = dr_w;
        adel_c = 1'b0;
        case (ld_type_w)
            LD_LW: begin
                adel_c = |ao_w[1:0];
            end
            LD_LH: begin
                load_c = {{16{half_c[15]}}, half_c};
                adel_c = ao_w[0];
            end
            LD_LHU: begin
                load_c = {16'h0000, half_c};
                adel_c = ao_w[0];
            end
            LD_LB:   load_c = {{24{byte_c[7]}}, byte_c};
            LD_LBU:  load_c = {24'h000000, byte_c};
            default: load_c = dr_w;
        endcase
    end

    // Write-data source select and effective write enable
    always_comb begin
        case (wd_sel_w)
            WD_LOAD: wd_c = load_c;
            WD_LINK: wd_c = pc4_w + XLEN'(4);
            default: wd_c = ao_w;
        endcase
        we_c = valid_w & regwrite_w & (a3_w != 5'd0) & ~adel_c;
    end

    // Retired-instruction counter; IntReq only cancels M, so it is ignored here
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            retired_q <= '0;
        end else if (valid_w && !adel_c) begin
            retired_q <= retired_q + RETIRE_W'(1);
        end
    end

    assign mw.WD_W    = wd_c;
    assign mw.A3_W    = a3_w;
    assign mw.WE_W    = we_c;
    assign mw.pc4_W   = pc4_w;
    assign mw.valid_W = valid_w;
    assign mw.adel_W  = adel_c;
    assign mw.retired = retired_q;

endmodule

// File: tb/tb_mw_load_stage.sv
// Directed bench for mw_load_stage with hand-computed expected values.
module tb_mw_load_stage;
    localparam int unsigned RETIRE_W = 4;

    logic clk;
    logic clr;
    int   errors;
    int   checks;

    mw_load_stage_if #(.RETIRE_W(RETIRE_W)) mw ();

    mw_load_stage #(.RETIRE_W(RETIRE_W)) dut (
        .clk (clk),
        .clr (clr),
        .mw  (mw)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file write trace
    always @(posedge clk) begin
        if (mw.WE_W)
            $display("%d@%h: $%d <= %h", $time, mw.pc4_W - 32'd4, mw.A3_W, mw.WD_W);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic m_in(input logic v, input logic [31:0] dr, input logic [31:0] ao,
                        input logic [31:0] pc4, input logic [2:0] ld, input logic [1:0] sel,
                        input logic rw, input logic [4:0] a3);
        mw.valid_M    = v;
        mw.DR         = dr;
        mw.AO_M       = ao;
        mw.pc4_M      = pc4;
        mw.ld_type_M  = ld;
        mw.wd_sel_M   = sel;
        mw.RegWrite_M = rw;
        mw.A3_M       = a3;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_wd"},    mw.WD_W, 32'h0);
        check({tag, "_a3"},    32'(mw.A3_W), 32'h0);
        check({tag, "_we"},    32'(mw.WE_W), 32'h0);
        check({tag, "_pc4"},   mw.pc4_W, 32'h0);
        check({tag, "_valid"}, 32'(mw.valid_W), 32'h0);
        check({tag, "_adel"},  32'(mw.adel_W), 32'h0);
        check({tag, "_ret"},   32'(mw.retired), 32'h0);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        clr = 1'b1;
        mw.IntReq = 1'b0;
        m_in(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd0);
        tick();
        tick();
        check_all_zero("reset");

        // release between edges with a valid M instruction waiting: no capture
        m_in(1'b1, 32'h8812F47F, 32'h100, 32'h1004, 3'd4, 2'd1, 1'b1, 5'd8);
        #2 clr = 1'b0;
        #1 check("release_no_capture", 32'(mw.valid_W), 32'h0);

        // lb sweep
        tick();
        check("lb0_wd", mw.WD_W, 32'h0000007F);
        check("lb0_we", 32'(mw.WE_W), 32'h1);
        check("lb0_ret", 32'(mw.retired), 32'd0);
        m_in(1'b1, 32'h8812F47F, 32'h101, 32'h1008, 3'd4, 2'd1, 1'b1, 5'd8);
        tick();
        check("lb1_wd", mw.WD_W, 32'hFFFFFFF4);
        check("lb1_ret", 32'(mw.retired), 32'd1);
        m_in(1'b1, 32'h8812F47F, 32'h102, 32'h100C, 3'd4, 2'd1, 1'b1, 5'd8);
        tick();
        check("lb2_wd", mw.WD_W, 32'h00000012);
        m_in(1'b1, 32'h8812F47F, 32'h103, 32'h1010, 3'd4, 2'd1, 1'b1, 5'd8);
        tick();
        check("lb3_wd", mw.WD_W, 32'hFFFFFF88);
        m_in(1'b1, 32'h8812F47F, 32'h103, 32'h1014, 3'd5, 2'd1, 1'b1, 5'd8);
        tick();
        check("lbu3_wd", mw.WD_W, 32'h00000088);
        check("lbu3_ret", 32'(mw.retired), 32'd4);

        // halfwords and misalignment
        m_in(1'b1, 32'h8001ABCD, 32'h102, 32'h1018, 3'd2, 2'd1, 1'b1, 5'd8);
        tick();
        check("lh2_wd", mw.WD_W, 32'hFFFF8001);
        m_in(1'b1, 32'h8001ABCD, 32'h100, 32'h101C, 3'd3, 2'd1, 1'b1, 5'd8);
        tick();
        check("lhu0_wd", mw.WD_W, 32'h0000ABCD);
        check("lhu0_adel", 32'(mw.adel_W), 32'h0);
        m_in(1'b1, 32'h8001ABCD, 32'h101, 32'h1020, 3'd2, 2'd1, 1'b1, 5'd8);
        tick();
        check("lh1_adel", 32'(mw.adel_W), 32'h1);
        check("lh1_we", 32'(mw.WE_W), 32'h0);
        check("lh1_ret", 32'(mw.retired), 32'd7);

        // link write; misaligned lh before it must not have counted
        m_in(1'b1, 32'h0, 32'h0, 32'h3008, 3'd0, 2'd2, 1'b1, 5'd31);
        tick();
        check("link_wd", mw.WD_W, 32'h0000300C);
        check("link_we", 32'(mw.WE_W), 32'h1);
        check("link_a3", 32'(mw.A3_W), 32'd31);
        check("link_pc4", mw.pc4_W, 32'h00003008);
        check("link_ret", 32'(mw.retired), 32'd7);

        // destination $0
        m_in(1'b1, 32'h0, 32'h55, 32'h300C, 3'd0, 2'd0, 1'b1, 5'd0);
        tick();
        check("r0_we", 32'(mw.WE_W), 32'h0);
        check("r0_valid", 32'(mw.valid_W), 32'h1);
        check("r0_wd", mw.WD_W, 32'h00000055);
        check("r0_ret", 32'(mw.retired), 32'd8);

        // interrupt cancels M; the $0 instruction in W still retires
        m_in(1'b1, 32'h0, 32'h77, 32'h3010, 3'd0, 2'd0, 1'b1, 5'd9);
        mw.IntReq = 1'b1;
        tick();
        mw.IntReq = 1'b0;
        check("irq_valid", 32'(mw.valid_W), 32'h0);
        check("irq_we", 32'(mw.WE_W), 32'h0);
        check("irq_ret", 32'(mw.retired), 32'd9);

        // lw aligned then misaligned
        m_in(1'b1, 32'hDEADBEEF, 32'h200, 32'h4004, 3'd1, 2'd1, 1'b1, 5'd3);
        tick();
        check("lw_wd", mw.WD_W, 32'hDEADBEEF);
        check("lw_ret", 32'(mw.retired), 32'd9);
        m_in(1'b1, 32'hDEADBEEF, 32'h202, 32'h4008, 3'd1, 2'd1, 1'b1, 5'd3);
        tick();
        check("lw2_adel", 32'(mw.adel_W), 32'h1);
        check("lw2_ret", 32'(mw.retired), 32'd10);

        // reserved encodings: ld_type 6 and wd_sel 3
        m_in(1'b1, 32'hCAFEF00D, 32'h1234, 32'h400C, 3'd6, 2'd3, 1'b1, 5'd4);
        tick();
        check("sel3_wd", mw.WD_W, 32'h00001234);
        check("sel3_adel", 32'(mw.adel_W), 32'h0);
        m_in(1'b1, 32'hCAFEF00D, 32'h1235, 32'h4010, 3'd7, 2'd1, 1'b1, 5'd4);
        tick();
        check("ld7_wd", mw.WD_W, 32'hCAFEF00D);
        check("ld7_ret", 32'(mw.retired), 32'd11);

        // asynchronous clear between edges
        #2 clr = 1'b1;
        #1 check_all_zero("async_clr");
        #1 clr = 1'b0;
        check("clr_release_valid", 32'(mw.valid_W), 32'h0);
        m_in(1'b1, 32'h0, 32'h10, 32'h5004, 3'd0, 2'd0, 1'b1, 5'd1);
        tick();
        check("resume0_ret", 32'(mw.retired), 32'd0);
        tick();
        check("resume1_ret", 32'(mw.retired), 32'd1);

        // counter wrap: 17 retirements into a 4-bit counter
        #2 clr = 1'b1;
        #1 clr = 1'b0;
        for (int i = 0; i < 17; i++) begin
            m_in(1'b1, 32'h0, 32'(i), 32'h6000 + 32'(4 * i), 3'd0, 2'd0, 1'b1, 5'd2);
            tick();
            if (i == 15) check("wrap_allones", 32'(mw.retired), 32'd15);
            if (i == 16) check("wrap_zero", 32'(mw.retired), 32'd0);
        end
        m_in(1'b0, 32'h0, 32'h0, 32'h0, 3'd0, 2'd0, 1'b0, 5'd0);
        tick();
        check("wrap_one", 32'(mw.retired), 32'd1);
        tick();
        check("bubble_ret", 32'(mw.retired), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
